// File: rtl/hidden_unit_reader.sv
// Burst reader: streams num_words hidden-unit RAM words from base_addr through a 2-entry skid buffer.
// Define HIDDEN_READER_RELU_EN to clamp negative (two's-complement) RAM words to zero before buffering.
module hidden_unit_reader #(
    parameter int DATA_WIDTH = 8,
    parameter int ADDR_WIDTH = 5
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  start,
    input  logic [ADDR_WIDTH-1:0] base_addr,
    input  logic [ADDR_WIDTH:0]   num_words,
    output logic [ADDR_WIDTH-1:0] ram_addr,
    input  logic [DATA_WIDTH-1:0] ram_q,
    output logic [DATA_WIDTH-1:0] out_data,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic                  busy,
    output logic                  done
);

    typedef enum logic [1:0] {IDLE, RUN, FINISH} state_t;

    localparam logic [ADDR_WIDTH:0] ONE = 1;

    state_t                state_q, state_d;
    logic [ADDR_WIDTH-1:0] base_q, base_d;
    logic [ADDR_WIDTH-1:0] ram_addr_q, ram_addr_d;
    logic [ADDR_WIDTH:0]   num_q, num_d;
    logic [ADDR_WIDTH:0]   issued_q, issued_d;
    logic [ADDR_WIDTH:0]   sent_q, sent_d;
    logic                  inflight_q, inflight_d;
    logic [1:0]            count_q, count_d;
    logic [DATA_WIDTH-1:0] buf0_q, buf0_d;
    logic [DATA_WIDTH-1:0] buf1_q, buf1_d;
    logic [DATA_WIDTH-1:0] cap_data;
    logic [2:0]            occupancy;
    logic [2:0]            limit;
    logic                  xfer;
    logic                  issue;

`ifdef HIDDEN_READER_RELU_EN
    assign cap_data = ram_q[DATA_WIDTH-1] ? '0 : ram_q;
`else
    assign cap_data = ram_q;
`endif

    assign xfer      = (count_q != 2'd0) && out_ready;
    assign occupancy = {1'b0, count_q} + {2'b00, inflight_q};
    assign limit     = 3'd2 + {2'b00, xfer};

    always_comb begin
        state_d    = state_q;
        base_d     = base_q;
        num_d      = num_q;
        issued_d   = issued_q;
        sent_d     = sent_q;
        issue      = 1'b0;
        ram_addr_d = ram_addr_q;
        buf0_d     = buf0_q;
        buf1_d     = buf1_q;

        case (state_q)
            IDLE: begin
                if (start) begin
                    base_d   = base_addr;
                    num_d    = num_words;
                    issued_d = '0;
                    sent_d   = '0;
                    state_d  = (num_words == '0) ? FINISH : RUN;
                end
            end
            RUN: begin
                // Room is judged after this cycle's pop so a full pipe still streams every cycle.
                issue = (issued_q < num_q) && (occupancy < limit);
                if (issue) begin
                    issued_d   = issued_q + ONE;
                    ram_addr_d = base_q + issued_q[ADDR_WIDTH-1:0];
                end
                if (xfer) begin
                    sent_d = sent_q + ONE;
                    if (sent_q + ONE == num_q) begin
                        state_d = FINISH;
                    end
                end
            end
            FINISH: state_d = IDLE;
            default: state_d = IDLE;
        endcase

        inflight_d = issue;
        count_d    = count_q + {1'b0, inflight_q} - {1'b0, xfer};

        // buf0 is always the head; the returning read lands behind whatever survives the pop.
        if (xfer && inflight_q) begin
            if (count_q == 2'd2) begin
                buf0_d = buf1_q;
                buf1_d = cap_data;
            end else begin
                buf0_d = cap_data;
            end
        end else if (xfer) begin
            buf0_d = buf1_q;
        end else if (inflight_q) begin
            if (count_q == 2'd0) begin
                buf0_d = cap_data;
            end else begin
                buf1_d = cap_data;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            base_q     <= '0;
            num_q      <= '0;
            issued_q   <= '0;
            sent_q     <= '0;
            ram_addr_q <= '0;
            inflight_q <= 1'b0;
            count_q    <= 2'd0;
            buf0_q     <= '0;
            buf1_q     <= '0;
        end else begin
            state_q    <= state_d;
            base_q     <= base_d;
            num_q      <= num_d;
            issued_q   <= issued_d;
            sent_q     <= sent_d;
            ram_addr_q <= ram_addr_d;
            inflight_q <= inflight_d;
            count_q    <= count_d;
            buf0_q     <= buf0_d;
            buf1_q     <= buf1_d;
        end
    end

    assign ram_addr  = ram_addr_d;
    assign out_data  = buf0_q;
    assign out_valid = (count_q != 2'd0);
    assign busy      = (state_q != IDLE);
    assign done      = (state_q == FINISH);

endmodule

// File: tb/tb_hidden_unit_reader.sv
// Scoreboard bench for hidden_unit_reader: a synchronous RAM model feeds the DUT, expected words are queued at start.
module tb_hidden_unit_reader;
    localparam int DW    = 8;
    localparam int AW    = 5;
    localparam int DEPTH = 32;

    logic          clk       = 1'b0;
    logic          rst_n     = 1'b0;
    logic          start     = 1'b0;
    logic [AW-1:0] base_addr = '0;
    logic [AW:0]   num_words = '0;
    logic [AW-1:0] ram_addr;
    logic [DW-1:0] ram_q;
    logic [DW-1:0] out_data;
    logic          out_valid;
    logic          out_ready = 1'b1;
    logic          busy;
    logic          done;

    hidden_unit_reader #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .base_addr(base_addr),
        .num_words(num_words), .ram_addr(ram_addr), .ram_q(ram_q),
        .out_data(out_data), .out_valid(out_valid), .out_ready(out_ready),
        .busy(busy), .done(done)
    );

    always #5 clk = ~clk;

    logic [DW-1:0] mem [DEPTH];
    always @(posedge clk) ram_q <= mem[ram_addr];

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int pass_cnt  = 0;
    int total_cnt = 0;

    logic [DW-1:0] exp_q [$];
    int  xfer_cnt, done_cnt, first_valid_cyc, first_xfer_cyc, last_xfer_cyc, done_cyc;
    int  ready_mode  = 0;
    int  ready_phase = 0;
    bit  stalled_prev = 1'b0;
    logic [DW-1:0] held_data;

    function automatic void check(string name, int act, int exp);
        total_cnt++;
        if (act == exp) pass_cnt++;
        else $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
    endfunction

    // Reference word for a burst index: RAM content at the wrapped address, optionally clamped.
    function automatic logic [DW-1:0] model_word(int unsigned a);
        int unsigned v;
        v = int'(mem[a % DEPTH]);
`ifdef HIDDEN_READER_RELU_EN
        if (v >= 128) v = 0;
`endif
        return DW'(v);
    endfunction

    always @(posedge clk) begin
        #1;
        case (ready_mode)
            0:       out_ready = 1'b1;
            1:       out_ready = ((ready_phase % 3) == 0);
            default: out_ready = 1'($urandom_range(0, 1));
        endcase
        ready_phase++;
    end

    // Monitor: pops the scoreboard on every transfer and watches stall stability and done pulses.
    always @(negedge clk) begin
        if (rst_n) begin
            if (out_valid && first_valid_cyc < 0) first_valid_cyc = cyc;
            if (stalled_prev) begin
                check("stall_valid_held", int'(out_valid), 1);
                check("stall_data_held", int'(out_data), int'(held_data));
            end
            if (out_valid && out_ready) begin
                if (exp_q.size() == 0) begin
                    total_cnt++;
                    $display("FAIL extra_word: got %0d expected no word (cycle %0d)", out_data, cyc);
                end else begin
                    check("word", int'(out_data), int'(exp_q.pop_front()));
                end
                if (xfer_cnt == 0) first_xfer_cyc = cyc;
                last_xfer_cyc = cyc;
                xfer_cnt++;
            end
            stalled_prev = out_valid && !out_ready;
            held_data    = out_data;
            if (done) begin
                done_cnt++;
                done_cyc = cyc;
            end
        end else begin
            stalled_prev = 1'b0;
        end
    end

    task automatic run_burst(input int unsigned b, input int unsigned n, input int mode,
                             input bit extra_start, input bit immediate);
        int s;
        ready_mode  = mode;
        ready_phase = 0;
        for (int unsigned i = 0; i < n; i++) exp_q.push_back(model_word(b + i));
        xfer_cnt = 0; done_cnt = 0; first_valid_cyc = -1; done_cyc = -1;
        if (!immediate) begin
            @(posedge clk); #1;
        end
        start = 1'b1; base_addr = AW'(b); num_words = (AW+1)'(n); s = cyc;
        @(posedge clk); #1;
        // A held start lands while busy and must be ignored; inputs also change after capture.
        start     = extra_start;
        base_addr = AW'($urandom);
        num_words = (AW+1)'($urandom_range(1, 32));
        @(posedge clk); #1;
        start = 1'b0;
        for (int k = 0; k < 400 && done_cnt == 0; k++) begin
            @(posedge clk); #1;
        end
        check("done_seen", int'(done_cnt > 0), 1);
        check("words_transferred", xfer_cnt, int'(n));
        check("scoreboard_empty", exp_q.size(), 0);
        if (n > 0) begin
            check("first_valid_latency", first_valid_cyc - s, 3);
            check("done_after_last_word", done_cyc - last_xfer_cyc, 1);
            if (mode == 0) check("no_bubbles", last_xfer_cyc - first_xfer_cyc, int'(n) - 1);
        end else begin
            check("empty_done_latency", done_cyc - s, 1);
            check("empty_never_valid", first_valid_cyc, -1);
        end
        repeat (4) @(posedge clk);
        #1;
        check("single_done_pulse", done_cnt, 1);
        check("idle_after_burst", int'(busy), 0);
        exp_q.delete();
    endtask

    initial begin
        for (int unsigned i = 0; i < DEPTH; i++) mem[i] = DW'(i);
        repeat (3) @(posedge clk);
        #1;
        check("reset_out_valid", int'(out_valid), 0);
        check("reset_busy", int'(busy), 0);
        check("reset_done", int'(done), 0);
        check("reset_ram_addr", int'(ram_addr), 0);
        check("reset_out_data", int'(out_data), 0);
        rst_n = 1'b1;

        run_burst(0, 32, 0, 1'b1, 1'b0);

        for (int unsigned i = 0; i < DEPTH; i++) mem[i] = DW'($urandom);
        run_burst(30, 4, 0, 1'b0, 1'b0);
        run_burst($urandom_range(0, 31), 8, 1, 1'b0, 1'b0);
        run_burst(5, 0, 0, 1'b1, 1'b0);

        // Reset after three words of a ten-word burst, then restart on the first free cycle.
        ready_mode = 0;
        for (int unsigned i = 0; i < 10; i++) exp_q.push_back(model_word(12 + i));
        xfer_cnt = 0; done_cnt = 0;
        @(posedge clk); #1;
        start = 1'b1; base_addr = AW'(12); num_words = (AW+1)'(10);
        @(posedge clk); #1;
        start = 1'b0;
        for (int k = 0; k < 100 && xfer_cnt < 3; k++) begin
            @(posedge clk); #1;
        end
        check("reset_prefix_words", xfer_cnt, 3);
        rst_n = 1'b0;
        @(posedge clk); #1;
        check("midreset_out_valid", int'(out_valid), 0);
        check("midreset_busy", int'(busy), 0);
        check("midreset_done", int'(done), 0);
        exp_q.delete();
        repeat (3) @(posedge clk);
        #1;
        check("midreset_no_done", done_cnt, 0);
        rst_n = 1'b1;
        run_burst(3, 10, 0, 1'b0, 1'b1);

        mem[0] = 8'hF0;
        mem[1] = 8'h05;
        run_burst(0, 2, 0, 1'b0, 1'b0);

        for (int r = 0; r < 6; r++) begin
            run_burst($urandom_range(0, 31), $urandom_range(0, 32), 2, 1'($urandom_range(0, 1)), 1'b0);
        end

        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end
endmodule
